vram_write_scheduler: RTL and testbench

Schedules pixel writes into the video RAM (`vga_ram_display`) so they never collide with display scan-out. Requesters push (x, y, pixel) writes through a valid/ready handshake into a small FIFO. The block drains that FIFO into the RAM write port only while `vga_controller` reports `display_active` low, with a programmable write budget per blanking interval. It sits between pattern/sprite generators and the RAM, replacing the ad-hoc `write_enable = !active` gating.

---
 rtl/vga_pkg.sv | 15 +
 rtl/vram_write_scheduler_if.sv | 11 +
 rtl/edge_detector.sv | 19 +
 rtl/pixel_write_fifo.sv | 45 ++++
 rtl/vram_write_scheduler.sv | 58 +++++
 tb/tb_vram_write_scheduler.sv | 223 ++++++++++++++++++++++
 6 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA geometry, scheduler FSM states and the pixel write record
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int COORD_W = 10;
  typedef enum logic [1:0] {SCAN, DRAIN, HOLD} wstate_e;
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               data;
  } pix_t;
  function automatic logic in_range(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    return (x < COORD_W'(H_ACTIVE)) && (y < COORD_W'(V_ACTIVE));
  endfunction
endpackage

// File: rtl/vram_write_scheduler_if.sv
// vram_write_scheduler_if: valid/ready pixel write request channel
interface vram_write_scheduler_if;
  import vga_pkg::*;
  logic               req_valid;
  logic               req_ready;
  logic [COORD_W-1:0] req_x;
  logic [COORD_W-1:0] req_y;
  logic               req_data;
  modport master(output req_valid, req_x, req_y, req_data, input req_ready);
  modport slave(input req_valid, req_x, req_y, req_data, output req_ready);
endinterface

// File: rtl/edge_detector.sv
// edge_detector: single-cycle pulse on a rising or falling edge of d
module edge_detector #(
  parameter bit FALL = 1'b0,
  parameter bit INIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);
  logic prev_q, prev_d;
  always_comb begin
    prev_d = d;
    pulse = FALL ? (prev_q && !d) : (!prev_q && d);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prev_q <= INIT;
    else prev_q <= prev_d;
endmodule

// File: rtl/pixel_write_fifo.sv
// pixel_write_fifo: synchronous FIFO with flush taking priority over push and pop
module pixel_write_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 21
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    full = cnt_q == (AW+1)'(DEPTH);
    empty = cnt_q == '0;
    do_push = push && !full && !flush;
    do_pop = pop && !empty && !flush;
    wr_d = flush ? '0 : wr_q + AW'(do_push);
    rd_d = flush ? '0 : rd_q + AW'(do_pop);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    dout = mem_q[rd_q];
    level = cnt_q;
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/vram_write_scheduler.sv
// vram_write_scheduler: drains queued pixel writes into VRAM only during blanking, under a per-interval budget
module vram_write_scheduler
  import vga_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_WRITES = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        flush,
  input  logic                        display_active,
  vram_write_scheduler_if.slave       req,
  output logic                        ram_we,
  output logic [COORD_W-1:0]          ram_x,
  output logic [COORD_W-1:0]          ram_y,
  output logic                        ram_wdata,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy
);
  localparam int BW = (MAX_WRITES == 0) ? 1 : $clog2(MAX_WRITES + 1);
  localparam logic [BW-1:0] BUDGET_INIT = BW'(MAX_WRITES);
  localparam bit UNLIM = MAX_WRITES == 0;
  wstate_e state_q, state_d;
  logic [BW-1:0] budget_q, budget_d;
  logic blank_start, full, empty, push;
  pix_t head;
  edge_detector #(.FALL(1'b1), .INIT(1'b1)) u_blank (
    .clk, .rst_n, .d(display_active), .pulse(blank_start)
  );
  pixel_write_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(pix_t))) u_fifo (
    .clk, .rst_n, .push, .pop(ram_we), .flush,
    .din({req.req_x, req.req_y, req.req_data}),
    .dout(head), .full, .empty, .level(fifo_level)
  );
  assign req.req_ready = !full;
  // out-of-range requests complete the handshake but never enter the queue
  assign push = req.req_valid && req.req_ready && in_range(req.req_x, req.req_y);
  assign busy = !empty;
  always_comb begin
    ram_we = (state_q == DRAIN) && !display_active && enable && !empty && (budget_q != '0 || UNLIM);
    ram_x = ram_we ? head.x : '0;
    ram_y = ram_we ? head.y : '0;
    ram_wdata = ram_we && head.data;
    budget_d = blank_start ? BUDGET_INIT : budget_q - BW'(ram_we && budget_q != '0);
    state_d = display_active ? SCAN
            : (state_q == SCAN) ? (blank_start ? DRAIN : SCAN)
            : (enable && (budget_d != '0 || UNLIM)) ? DRAIN : HOLD;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= SCAN;
      budget_q <= '0;
    end else begin
      state_q <= state_d;
      budget_q <= budget_d;
    end
endmodule

// File: tb/tb_vram_write_scheduler.sv
// tb_vram_write_scheduler: directed checks of blanking-gated VRAM write scheduling
module tb_vram_write_scheduler;
  import vga_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1, flush = 1'b0, display_active = 1'b1;
  logic req_valid = 1'b0, req_data = 1'b0;
  logic [9:0] req_x = '0, req_y = '0;
  logic we_a, wd_a, busy_a, we_b, wd_b, busy_b;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic [3:0] lvl_a, lvl_b;
  int n_cmp = 0, n_err = 0;
  vram_write_scheduler_if ia();
  vram_write_scheduler_if ib();
  assign ia.req_valid = req_valid;
  assign ia.req_x = req_x;
  assign ia.req_y = req_y;
  assign ia.req_data = req_data;
  assign ib.req_valid = req_valid;
  assign ib.req_x = req_x;
  assign ib.req_y = req_y;
  assign ib.req_data = req_data;
  vram_write_scheduler #(.FIFO_DEPTH(8), .MAX_WRITES(16)) ua (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush), .display_active(display_active),
    .req(ia), .ram_we(we_a), .ram_x(x_a), .ram_y(y_a), .ram_wdata(wd_a),
    .fifo_level(lvl_a), .busy(busy_a)
  );
  vram_write_scheduler #(.FIFO_DEPTH(8), .MAX_WRITES(2)) ub (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush), .display_active(display_active),
    .req(ib), .ram_we(we_b), .ram_x(x_b), .ram_y(y_b), .ram_wdata(wd_b),
    .fifo_level(lvl_b), .busy(busy_b)
  );
  always #5 clk = ~clk;

  task automatic reset_dut();
    rst_n = 1'b0; display_active = 1'b1; enable = 1'b1; flush = 1'b0;
    req_valid = 1'b0; req_x = '0; req_y = '0; req_data = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push(input logic [9:0] x, input logic [9:0] y, input logic d);
    req_valid = 1'b1; req_x = x; req_y = y; req_data = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (ia.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0h want 1", ia.req_ready); end
    n_cmp++; if (we_a !== 1'b0) begin n_err++; $display("FAIL reset_we: got %0h want 0", we_a); end
    n_cmp++; if ({x_a, y_a, wd_a} !== 21'd0) begin n_err++; $display("FAIL reset_xyd: got %0h want 0", {x_a, y_a, wd_a}); end
    n_cmp++; if (lvl_a !== 4'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", lvl_a); end
    n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0h want 0", busy_a); end
    n_cmp++; if (ua.state_q !== SCAN) begin n_err++; $display("FAIL reset_state: got %0d want %0d", ua.state_q, SCAN); end
    n_cmp++; if (ua.budget_q !== 5'd0) begin n_err++; $display("FAIL reset_budget: got %0d want 0", ua.budget_q); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_in_order();
    reset_dut();
    for (int i = 0; i < 3; i++) push(10'(20 * i + 10), 10'(20 * i + 20), i != 1);
    n_cmp++; if (lvl_a !== 4'd3) begin n_err++; $display("FAIL order_level: got %0d want 3", lvl_a); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++; if (we_a !== 1'b0) begin n_err++; $display("FAIL order_scan_we: got %0h want 0", we_a); end
    end
    display_active = 1'b0;
    #1;
    n_cmp++; if (we_a !== 1'b0) begin n_err++; $display("FAIL order_fall_cycle_we: got %0h want 0", we_a); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({we_a, x_a, y_a, wd_a} !== {1'b1, 10'(20 * i + 10), 10'(20 * i + 20), i != 1}) begin
        n_err++; $display("FAIL order_write%0d: got we=%0h x=%0d y=%0d d=%0h want we=1 x=%0d y=%0d d=%0h",
                          i, we_a, x_a, y_a, wd_a, 20 * i + 10, 20 * i + 20, i != 1);
      end
    end
    @(negedge clk);
    n_cmp++; if ({we_a, lvl_a} !== 5'd0) begin n_err++; $display("FAIL order_drained: got we=%0h lvl=%0d want 0 0", we_a, lvl_a); end
    display_active = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_budget();
    int cnt;
    reset_dut();
    for (int i = 0; i < 5; i++) push(10'(i), 10'(i + 100), i[0]);
    display_active = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_cmp++; if ({we_b, x_b, y_b, wd_b} !== {1'b1, 10'd0, 10'd100, 1'b0}) begin n_err++; $display("FAIL budget_first: got we=%0h x=%0d y=%0d d=%0h want 1 0 100 0", we_b, x_b, y_b, wd_b); end
      end
      if (we_b) cnt++;
    end
    n_cmp++; if (cnt !== 2) begin n_err++; $display("FAIL budget_count1: got %0d want 2", cnt); end
    n_cmp++; if (lvl_b !== 4'd3) begin n_err++; $display("FAIL budget_level1: got %0d want 3", lvl_b); end
    n_cmp++; if (ub.state_q !== HOLD) begin n_err++; $display("FAIL budget_hold: got %0d want %0d", ub.state_q, HOLD); end
    n_cmp++; if (busy_b !== 1'b1) begin n_err++; $display("FAIL budget_busy: got %0h want 1", busy_b); end
    display_active = 1'b1;
    repeat (2) @(negedge clk);
    display_active = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (we_b) cnt++;
    end
    n_cmp++; if (cnt !== 2) begin n_err++; $display("FAIL budget_count2: got %0d want 2", cnt); end
    n_cmp++; if (lvl_b !== 4'd1) begin n_err++; $display("FAIL budget_level2: got %0d want 1", lvl_b); end
    display_active = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full();
    reset_dut();
    for (int i = 0; i < 8; i++) push(10'(i), 10'(i), 1'b0);
    n_cmp++; if ({ia.req_ready, lvl_a} !== {1'b0, 4'd8}) begin n_err++; $display("FAIL full_state: got rdy=%0h lvl=%0d want 0 8", ia.req_ready, lvl_a); end
    req_valid = 1'b1; req_x = 10'd100; req_y = 10'd100; req_data = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if ({ia.req_ready, lvl_a} !== {1'b0, 4'd8}) begin n_err++; $display("FAIL full_held: got rdy=%0h lvl=%0d want 0 8", ia.req_ready, lvl_a); end
    display_active = 1'b0;
    @(negedge clk);
    n_cmp++; if ({we_a, x_a, ia.req_ready, lvl_a} !== {1'b1, 10'd0, 1'b0, 4'd8}) begin n_err++; $display("FAIL full_first_pop: got we=%0h x=%0d rdy=%0h lvl=%0d want 1 0 0 8", we_a, x_a, ia.req_ready, lvl_a); end
    @(negedge clk);
    n_cmp++; if ({we_a, x_a, ia.req_ready, lvl_a} !== {1'b1, 10'd1, 1'b1, 4'd7}) begin n_err++; $display("FAIL full_ready_rise: got we=%0h x=%0d rdy=%0h lvl=%0d want 1 1 1 7", we_a, x_a, ia.req_ready, lvl_a); end
    @(negedge clk);
    n_cmp++; if ({we_a, x_a, lvl_a} !== {1'b1, 10'd2, 4'd7}) begin n_err++; $display("FAIL full_push_pop: got we=%0h x=%0d lvl=%0d want 1 2 7", we_a, x_a, lvl_a); end
    req_valid = 1'b0;
    display_active = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_retry();
    reset_dut();
    for (int i = 0; i < 6; i++) push(10'(i + 1), 10'd0, 1'b1);
    display_active = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({we_a, x_a, lvl_a} !== {1'b1, 10'd3, 4'd4}) begin n_err++; $display("FAIL retry_mid: got we=%0h x=%0d lvl=%0d want 1 3 4", we_a, x_a, lvl_a); end
    display_active = 1'b1;
    #1;
    n_cmp++; if (we_a !== 1'b0) begin n_err++; $display("FAIL retry_same_cycle_we: got %0h want 0", we_a); end
    @(negedge clk);
    n_cmp++; if ({we_a, lvl_a} !== {1'b0, 4'd4}) begin n_err++; $display("FAIL retry_kept: got we=%0h lvl=%0d want 0 4", we_a, lvl_a); end
    display_active = 1'b0;
    @(negedge clk);
    n_cmp++; if ({we_a, x_a} !== {1'b1, 10'd3}) begin n_err++; $display("FAIL retry_head: got we=%0h x=%0d want 1 3", we_a, x_a); end
    display_active = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_range();
    int cnt;
    reset_dut();
    push(10'd700, 10'd10, 1'b1);
    push(10'd5, 10'd5, 1'b1);
    n_cmp++; if (lvl_a !== 4'd1) begin n_err++; $display("FAIL range_level: got %0d want 1", lvl_a); end
    display_active = 1'b0;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (we_a) begin
        cnt++;
        n_cmp++; if ({x_a, y_a} !== {10'd5, 10'd5}) begin n_err++; $display("FAIL range_write: got x=%0d y=%0d want 5 5", x_a, y_a); end
      end
    end
    n_cmp++; if (cnt !== 1) begin n_err++; $display("FAIL range_count: got %0d want 1", cnt); end
    display_active = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_flush();
    int cnt;
    reset_dut();
    for (int i = 0; i < 6; i++) push(10'(i), 10'(i), 1'b1);
    n_cmp++; if (lvl_a !== 4'd6) begin n_err++; $display("FAIL flush_pre_level: got %0d want 6", lvl_a); end
    flush = 1'b1; req_valid = 1'b1; req_x = 10'd7; req_y = 10'd7; req_data = 1'b1;
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    n_cmp++; if ({lvl_a, busy_a, ia.req_ready} !== {4'd0, 1'b0, 1'b1}) begin n_err++; $display("FAIL flush_level: got lvl=%0d busy=%0h rdy=%0h want 0 0 1", lvl_a, busy_a, ia.req_ready); end
    display_active = 1'b0;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (we_a) cnt++;
    end
    n_cmp++; if (cnt !== 0) begin n_err++; $display("FAIL flush_writes: got %0d want 0", cnt); end
    display_active = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    reset_dut();
    for (int i = 0; i < 4; i++) push(10'(i + 1), 10'(i + 1), 1'b1);
    display_active = 1'b0;
    @(negedge clk);
    n_cmp++; if ({we_a, x_a} !== {1'b1, 10'd1}) begin n_err++; $display("FAIL arst_draining: got we=%0h x=%0d want 1 1", we_a, x_a); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({we_a, x_a, y_a, wd_a} !== 22'd0) begin n_err++; $display("FAIL arst_ram: got %0h want 0", {we_a, x_a, y_a, wd_a}); end
    n_cmp++; if ({lvl_a, busy_a, ia.req_ready} !== {4'd0, 1'b0, 1'b1}) begin n_err++; $display("FAIL arst_fifo: got lvl=%0d busy=%0h rdy=%0h want 0 0 1", lvl_a, busy_a, ia.req_ready); end
    n_cmp++; if (ua.state_q !== SCAN) begin n_err++; $display("FAIL arst_state: got %0d want %0d", ua.state_q, SCAN); end
    @(negedge clk);
    display_active = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_budget();
    test_full();
    test_retry();
    test_range();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
